debounce_sync: RTL
==================

// Module: debounce_sync
// PURPOSE
//  Input conditioner sitting directly upstream of the latch/flip-flop storage-element
//  comparison stage; its d_out drives that stage's d input.
//  Synchronises an asynchronous raw input (switch/pin) into the clk domain and debounces it.
//  Emits a clean level plus one-cycle rise/fall pulses.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser flop count; legal range >=2.
//  DB_CYCLES    4  consecutive synced cycles a new level must hold before acceptance; legal range >=2.
//  CNT_W        $clog2(DB_CYCLES)+1  debounce counter width; localparam, not overridable.
// PORTS
//  clk        in   1  single clock; all state updates on posedge.
//  reset      in   1  synchronous, active-high reset.
//  din        in   1  raw asynchronous input.
//  d_out      out  1  debounced level; feeds the storage stage d input.
//  rise       out  1  one-cycle pulse when d_out goes 0->1.
//  fall       out  1  one-cycle pulse when d_out goes 1->0.
//  glitch_cnt out  8  present only with GLITCH_COUNT_EN.
// BEHAVIOUR
//  - Reset, sampled at posedge:
//    - sync chain, d_out, rise, fall, counter and glitch_cnt all go to 0.
//    - FSM goes to S_LOW.
//    - Reset asserted mid-debounce aborts the debounce with no pulse emitted.
//  - Synchroniser: din shifts through SYNC_STAGES flops; din_sync is the last stage.
//  - FSM states: S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO. d_out=1 only in S_HIGH and S_WAIT_LO.
//    - S_LOW: din_sync=1 -> S_WAIT_HI, cnt<=1. Otherwise stay, cnt<=0.
//    - S_WAIT_HI, din_sync=0: -> S_LOW, cnt<=0. This is a glitch.
//    - S_WAIT_HI, cnt==DB_CYCLES-1: -> S_HIGH, d_out<=1, rise<=1.
//    - S_WAIT_HI, otherwise: cnt<=cnt+1.
//    - S_HIGH and S_WAIT_LO: mirror images of S_LOW and S_WAIT_HI with polarity inverted.
//      S_WAIT_LO completion gives S_LOW, d_out<=0, fall<=1.
//  - Latency: a din step stable before rising edge #1 sets d_out after rising edge
//    #(SYNC_STAGES+DB_CYCLES). Defaults: edge #6 = 120 ns at a 20 ns period.
//  - rise/fall:
//    - Registered; asserted in the same cycle d_out changes, deasserted the next cycle.
//    - rise and fall are never asserted together.
//  - Input pulses shorter than SYNC_STAGES... see cycle counts below:
//    - Synced pulses shorter than DB_CYCLES cycles never change d_out.
//    - A synced level held exactly DB_CYCLES cycles is accepted.
//  - Counter never exceeds DB_CYCLES-1; no wrap is possible.
//  - Input toggling on every cycle keeps d_out constant indefinitely.
// CONFIGURATION
//  GLITCH_COUNT_EN defined:
//   - glitch_cnt port exists.
//   - It increments on every S_WAIT_HI->S_LOW and S_WAIT_LO->S_HIGH abort.
//   - It saturates at 255 and does not wrap.
//   - It clears only on reset.
//  GLITCH_COUNT_EN undefined:
//   - The port and counter logic are absent.
//   - All other behaviour is identical, cycle for cycle.
// TESTING
//  - Clock period 20 ns. Reset held for 2 cycles, din=1 during reset.
//    -> d_out=0, rise=0, fall=0 throughout reset. glitch_cnt=0.
//  - din 0->1 held steady.
//    -> d_out=1 after the 6th rising edge. rise high exactly 1 cycle (20 ns). fall stays 0.
//  - din=1 (d_out=1), then bursts 0 for 2 ns, 3 ns and 4 ns between edges (each fits within one period).
//    -> d_out stays 1. No pulses.
//  - din=1 (d_out=1), then din=0 for exactly 3 synced cycles, then back to 1.
//    -> d_out stays 1. glitch_cnt increments by 1 when GLITCH_COUNT_EN is defined.
//  - din=1 (d_out=1), then din=0 held 4+ cycles.
//    -> d_out=0 at edge 6 after the change. fall pulses 1 cycle.
//  - Reset asserted while in S_WAIT_HI (cnt=2).
//    -> next edge: d_out=0, no rise. Debounce restarts after reset release.

Source files
------------

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw asynchronous input into a clean level plus rise/fall pulses.
// Optional saturating glitch counter when GLITCH_COUNT_EN is defined.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       d_out,
    output logic       rise,
    output logic       fall
`ifdef GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HI,
        S_HIGH,
        S_WAIT_LO
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_sync;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_d, fall_d, abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign din_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            d_out   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out   <= (state_d == S_HIGH) || (state_d == S_WAIT_LO);
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // A return to the held level while waiting is an abort; it takes priority over completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_LOW: begin
                if (din_sync) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_WAIT_HI: begin
                if (!din_sync) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!din_sync) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_WAIT_LO: begin
                if (din_sync) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef GLITCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if (abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule
